stw_scheduler: RTL and testbench
================================

STW_SCHEDULER -- requirements
Module: stw_scheduler

Interface
REQ-001 Parameter WORD_SIZE, 16, operand/result width of each MAC PE.
REQ-002 Parameter NUM_PE, 4, number of MAC PEs under test.
REQ-003 Parameter TIMEOUT, 8, maximum WAIT cycles per vector (used only with STW_TIMEOUT_EN).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 test_req  in  1  request one full self-test sweep.
REQ-007 sa_idle  in  1  array not executing matmul; sweep may begin only when high.
REQ-008 stw_complete  in  NUM_PE  per-PE STW complete flag.
REQ-009 stw_result  in  NUM_PE  per-PE pass flag (1 = pass).
REQ-010 stw_load_en  out  1  loads the test operands into every PE.
REQ-011 stw_mult_op1, stw_mult_op2, stw_add_op, stw_expected  out  WORD_SIZE each  current test vector, broadcast to all PEs.
REQ-012 stw_start  out  NUM_PE  per-PE start pulse.
REQ-013 test_busy  out  1  sweep in progress.
REQ-014 test_done  out  1  one-cycle pulse at sweep end.
REQ-015 fault_map  out  NUM_PE  1 = PE failed at least one vector in the last sweep.
REQ-016 fault_any  out  1  OR-reduction of fault_map.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, START, GUARD, WAIT and DONE.
REQ-018 IDLE->LOAD SHALL occur when test_req=1 and sa_idle=1; the same edge clears fault_map and sets vec_idx=0.
REQ-019 test_req SHALL be ignored outside IDLE; test_req with sa_idle=0 SHALL hold the FSM in IDLE.
REQ-020 LOAD SHALL assert stw_load_en for exactly 1 cycle, with the operand outputs driven from vector vec_idx; LOAD->START.
REQ-021 START SHALL assert stw_start to all PEs for exactly 1 cycle; START->GUARD.
REQ-022 GUARD SHALL last 1 cycle, ignore stw_complete and go to WAIT.
REQ-023 WAIT SHALL remain until stw_complete is all-ones; on that edge, fault_map |= ~stw_result.
REQ-024 On leaving WAIT, the FSM SHALL go to LOAD with vec_idx+1, or to DONE if vec_idx = NUM_VEC-1.
REQ-025 DONE SHALL pulse test_done for 1 cycle and return to IDLE.
REQ-026 Nominal latency SHALL be 4 cycles per vector; the accept edge to the test_done cycle SHALL be 4*NUM_VEC+1 cycles.
REQ-027 test_busy SHALL be 1 in every state except IDLE.
REQ-028 Operand outputs SHALL hold their value outside LOAD; stw_expected SHALL be (op1*op2+add) truncated to WORD_SIZE (modulo 2^WORD_SIZE).
REQ-029 fault_map SHALL hold its value from DONE until the next accepted request.

Reset
REQ-030 On rst, including mid-sweep, the block SHALL go to IDLE, and vec_idx, timeout counter, fault_map, fault_any, test_busy, test_done, stw_load_en, stw_start and all operand outputs SHALL be 0.

Configuration
REQ-031 With STW_TIMEOUT_EN defined, a counter SHALL be cleared on WAIT entry; after TIMEOUT WAIT cycles, fault_map |= ~stw_complete | ~stw_result, and the FSM SHALL advance as in REQ-024.
REQ-032 Without STW_TIMEOUT_EN, WAIT SHALL wait indefinitely and no counter logic SHALL exist.

Structure
REQ-033 Package stw_pkg SHALL hold the state enum, NUM_VEC=4 and the vector table: V0 {3,5,7,22}; V1 {FFFF,FFFF,0,0001}; V2 {AAAA,0001,5555,FFFF}; V3 {0,1234,0,0}.
REQ-034 One sub-module, stw_vec_rom (vec_idx -> four operand words, combinational), SHALL be used.

Verification
REQ-035 Healthy PE models (complete low 1 cycle after start, high the next), test_req=1, sa_idle=1 -> four load/start pairs, test_done at cycle 17, fault_map=0000, fault_any=0.
REQ-036 PE2 returns stw_result=0 on V1 only -> fault_map=0100, fault_any=1, test_done still at cycle 17.
REQ-037 test_req=1 with sa_idle=0 for 5 cycles, then sa_idle=1 -> LOAD 1 cycle after sa_idle rises; test_req pulses during a sweep have no effect.
REQ-038 rst asserted in WAIT of V2 -> next cycle all outputs 0, FSM IDLE; a new request runs a full 4-vector sweep.
REQ-039 STW_TIMEOUT_EN defined, PE0 never completes -> each vector leaves WAIT after 8 cycles, fault_map=0001; without the macro the bench observes WAIT held indefinitely.
REQ-040 Two back-to-back sweeps, the first with PE3 failing and the second healthy -> fault_map=1000 after the first, then cleared on accept and 0000 after the second.

Source files
------------

// File: rtl/stw_pkg.sv
// Shared definitions for the systolic-array self-test wrapper (STW) scheduler:
// FSM state encodings, sweep length and the built-in test vector table.
package stw_pkg;

  localparam int unsigned NUM_VEC = 4;
  localparam int unsigned VecIdxW = $clog2(NUM_VEC);

  // FSM state encoding (plain constants for compatibility with older flows).
  typedef logic [2:0] stw_state_t;
  localparam stw_state_t StIdle  = 3'd0;
  localparam stw_state_t StLoad  = 3'd1;
  localparam stw_state_t StStart = 3'd2;
  localparam stw_state_t StGuard = 3'd3;
  localparam stw_state_t StWait  = 3'd4;
  localparam stw_state_t StDone  = 3'd5;

  // Stored operands only; the expected word is derived from them at the
  // configured width so the table stays valid for any WORD_SIZE.
  typedef struct packed {
    logic [15:0] op1;
    logic [15:0] op2;
    logic [15:0] add;
  } stw_vec_t;

  // V0 3*5+7=22, V1 FFFF*FFFF+0=0001, V2 AAAA*1+5555=FFFF, V3 0*1234+0=0.
  function automatic stw_vec_t vec_lookup(input logic [VecIdxW-1:0] idx);
    stw_vec_t v;
    case (idx)
      2'd0:    v = '{op1: 16'h0003, op2: 16'h0005, add: 16'h0007};
      2'd1:    v = '{op1: 16'hFFFF, op2: 16'hFFFF, add: 16'h0000};
      2'd2:    v = '{op1: 16'hAAAA, op2: 16'h0001, add: 16'h5555};
      default: v = '{op1: 16'h0000, op2: 16'h1234, add: 16'h0000};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/stw_vec_rom.sv
// Combinational test-vector ROM: vector index -> three operands plus the
// expected MAC result (op1*op2+add, truncated to WORD_SIZE).
module stw_vec_rom
  import stw_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 16
) (
  input  logic [VecIdxW-1:0]   vec_idx_i,
  output logic [WORD_SIZE-1:0] op1_o,
  output logic [WORD_SIZE-1:0] op2_o,
  output logic [WORD_SIZE-1:0] add_o,
  output logic [WORD_SIZE-1:0] exp_o
);

  stw_vec_t vec;

  // Table lookup and reference MAC; the product wraps at WORD_SIZE.
  always_comb begin
    vec   = vec_lookup(vec_idx_i);
    op1_o = WORD_SIZE'(vec.op1);
    op2_o = WORD_SIZE'(vec.op2);
    add_o = WORD_SIZE'(vec.add);
    exp_o = op1_o * op2_o + add_o;
  end

endmodule

// File: rtl/stw_scheduler.sv
// Self-test sweep scheduler: on request (while the array is idle) it walks
// every built-in vector through all MAC PEs (load, start, guard, wait) and
// accumulates a per-PE fault map.
// Optional feature: define STW_TIMEOUT_EN to bound each WAIT to TIMEOUT
// cycles; PEs still incomplete at that point are marked faulty.
module stw_scheduler
  import stw_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned NUM_PE    = 4,
  parameter int unsigned TIMEOUT   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 test_req,
  input  logic                 sa_idle,
  input  logic [NUM_PE-1:0]    stw_complete,
  input  logic [NUM_PE-1:0]    stw_result,
  output logic                 stw_load_en,
  output logic [WORD_SIZE-1:0] stw_mult_op1,
  output logic [WORD_SIZE-1:0] stw_mult_op2,
  output logic [WORD_SIZE-1:0] stw_add_op,
  output logic [WORD_SIZE-1:0] stw_expected,
  output logic [NUM_PE-1:0]    stw_start,
  output logic                 test_busy,
  output logic                 test_done,
  output logic [NUM_PE-1:0]    fault_map,
  output logic                 fault_any
);

  if (TIMEOUT < 1) begin : g_timeout_chk
    $error("stw_scheduler: TIMEOUT must be at least 1");
  end

  stw_state_t          state_q, state_d;
  logic [VecIdxW-1:0]  vec_idx_q, vec_idx_d;
  logic [NUM_PE-1:0]   fault_map_q, fault_map_d;
  logic                load_en_q;
  logic [NUM_PE-1:0]   start_q;
  logic                done_q;
  logic [WORD_SIZE-1:0] op1_q, op2_q, add_q, exp_q;
  logic [WORD_SIZE-1:0] rom_op1, rom_op2, rom_add, rom_exp;
  logic                all_complete;
  logic                wait_exit;
  logic [NUM_PE-1:0]   wait_fault;

  // Indexed by the next vector so operands are registered on LOAD entry.
  stw_vec_rom #(
    .WORD_SIZE(WORD_SIZE)
  ) u_vec_rom (
    .vec_idx_i(vec_idx_d),
    .op1_o    (rom_op1),
    .op2_o    (rom_op2),
    .add_o    (rom_add),
    .exp_o    (rom_exp)
  );

  assign all_complete = &stw_complete;

`ifdef STW_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            tmo_hit;

  assign tmo_hit    = (tmo_cnt_q == CntW'(TIMEOUT - 1));
  assign wait_exit  = all_complete | tmo_hit;
  // With every PE complete this reduces to ~stw_result.
  assign wait_fault = ~stw_complete | ~stw_result;

  // Count WAIT cycles; zero whenever not waiting, so each WAIT starts at 0.
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == StWait && !wait_exit) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign wait_exit  = all_complete;
  assign wait_fault = ~stw_result;
`endif

  // Sweep sequencing, vector stepping and fault accumulation.
  always_comb begin
    state_d     = state_q;
    vec_idx_d   = vec_idx_q;
    fault_map_d = fault_map_q;
    case (state_q)
      StIdle: begin
        if (test_req && sa_idle) begin
          state_d     = StLoad;
          vec_idx_d   = '0;
          fault_map_d = '0;
        end
      end
      StLoad:  state_d = StStart;
      StStart: state_d = StGuard;
      // PEs may still show the previous vector's completion here.
      StGuard: state_d = StWait;
      StWait: begin
        if (wait_exit) begin
          fault_map_d = fault_map_q | wait_fault;
          if (vec_idx_q == VecIdxW'(NUM_VEC - 1)) begin
            state_d = StDone;
          end else begin
            state_d   = StLoad;
            vec_idx_d = vec_idx_q + 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM state, vector index and fault map registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      vec_idx_q   <= '0;
      fault_map_q <= '0;
    end else begin
      state_q     <= state_d;
      vec_idx_q   <= vec_idx_d;
      fault_map_q <= fault_map_d;
    end
  end

  // Registered strobes and operands, decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_en_q <= 1'b0;
      start_q   <= '0;
      done_q    <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      add_q     <= '0;
      exp_q     <= '0;
    end else begin
      load_en_q <= (state_d == StLoad);
      start_q   <= {NUM_PE{state_d == StStart}};
      done_q    <= (state_d == StDone);
      if (state_d == StLoad) begin
        op1_q <= rom_op1;
        op2_q <= rom_op2;
        add_q <= rom_add;
        exp_q <= rom_exp;
      end
    end
  end

  assign stw_load_en  = load_en_q;
  assign stw_start    = start_q;
  assign test_done    = done_q;
  assign stw_mult_op1 = op1_q;
  assign stw_mult_op2 = op2_q;
  assign stw_add_op   = add_q;
  assign stw_expected = exp_q;
  assign test_busy    = (state_q != StIdle);
  assign fault_map    = fault_map_q;
  assign fault_any    = |fault_map_q;

endmodule

// File: tb/tb_stw_scheduler.sv
// Directed self-checking bench for stw_scheduler with simple PE models.
module tb_stw_scheduler;

  localparam int unsigned Timeout = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        test_req = 1'b0;
  logic        sa_idle = 1'b0;
  logic [3:0]  stw_complete, stw_result;
  logic        stw_load_en;
  logic [15:0] stw_mult_op1, stw_mult_op2, stw_add_op, stw_expected;
  logic [3:0]  stw_start;
  logic        test_busy, test_done;
  logic [3:0]  fault_map;
  logic        fault_any;

  stw_scheduler #(
    .WORD_SIZE(16),
    .NUM_PE   (4),
    .TIMEOUT  (Timeout)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .test_req    (test_req),
    .sa_idle     (sa_idle),
    .stw_complete(stw_complete),
    .stw_result  (stw_result),
    .stw_load_en (stw_load_en),
    .stw_mult_op1(stw_mult_op1),
    .stw_mult_op2(stw_mult_op2),
    .stw_add_op  (stw_add_op),
    .stw_expected(stw_expected),
    .stw_start   (stw_start),
    .test_busy   (test_busy),
    .test_done   (test_done),
    .fault_map   (fault_map),
    .fault_any   (fault_any)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // PE behaviour knobs: hung PEs never complete; failing PEs report
  // result=0 on the vectors flagged in fail_vecs.
  logic [3:0] hang_pe = 4'h0;
  logic [3:0] fail_pe = 4'h0;
  logic [3:0] fail_vecs = 4'h0;
  logic [3:0] pe_cmpl;
  logic [2:0] ld_n;
  logic [2:0] vcur;

  // Complete drops the cycle after start and returns the cycle after that.
  always @(posedge clk) begin
    if (rst) pe_cmpl <= 4'hF;
    else     pe_cmpl <= ~stw_start & ~hang_pe;
  end

  // Tracks which vector the PEs are currently working on.
  always @(posedge clk) begin
    if (rst || test_done) ld_n <= 3'd0;
    else if (stw_load_en) ld_n <= ld_n + 3'd1;
  end

  always_comb begin
    vcur       = ld_n - 3'd1;
    stw_result = fail_vecs[vcur[1:0]] ? ~fail_pe : 4'hF;
  end

  assign stw_complete = pe_cmpl;

  // Hand-computed vector table.
  logic [15:0] exp_op1 [4] = '{16'h0003, 16'hFFFF, 16'hAAAA, 16'h0000};
  logic [15:0] exp_op2 [4] = '{16'h0005, 16'hFFFF, 16'h0001, 16'h1234};
  logic [15:0] exp_add [4] = '{16'h0007, 16'h0000, 16'h5555, 16'h0000};
  logic [15:0] exp_res [4] = '{16'h0016, 16'h0001, 16'hFFFF, 16'h0000};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a request; returns just after the accepting edge.
  task automatic accept_req();
    @(negedge clk);
    test_req = 1'b1;
    sa_idle  = 1'b1;
    @(posedge clk);
  endtask

  // Follow one sweep from the accept edge: cycle n is the n-th negedge after it.
  task automatic watch_sweep(input string tag, input int per, input logic [3:0] exp_fault,
                             input bit pulse);
    int nload = 0;
    int nstart = 0;
    int busy_bad = 0;
    bit seen_done = 1'b0;
    int done_cyc = 4 * per + 1;
    for (int cyc = 1; cyc <= done_cyc + 10 && !seen_done; cyc++) begin
      @(negedge clk);
      test_req = pulse && (cyc == 7 || cyc == 12);
      if (cyc == 1) check_eq({tag, "_fault_clr"}, fault_map, 4'h0);
      if (cyc == 3) check_eq({tag, "_op_hold"}, stw_mult_op1, 16'h0003);
      if (!test_busy) busy_bad++;
      if (stw_load_en) begin
        if (nload < 4) begin
          check_eq({tag, "_load_cyc"}, cyc, per * nload + 1);
          check_eq({tag, "_ops"}, {stw_mult_op1, stw_mult_op2, stw_add_op, stw_expected},
                   {exp_op1[nload], exp_op2[nload], exp_add[nload], exp_res[nload]});
        end
        nload++;
      end
      if (stw_start != 4'h0) begin
        check_eq({tag, "_start_val"}, stw_start, 4'hF);
        check_eq({tag, "_start_cyc"}, cyc, per * nstart + 2);
        nstart++;
      end
      if (test_done) begin
        check_eq({tag, "_done_cyc"}, cyc, done_cyc);
        seen_done = 1'b1;
      end
    end
    test_req = 1'b0;
    check_eq({tag, "_done_seen"}, seen_done, 1'b1);
    check_eq({tag, "_busy"}, busy_bad, 0);
    check_eq({tag, "_nload"}, nload, 4);
    check_eq({tag, "_nstart"}, nstart, 4);
    check_eq({tag, "_fault_map"}, fault_map, exp_fault);
    check_eq({tag, "_fault_any"}, fault_any, |exp_fault);
    @(negedge clk);
    check_eq({tag, "_idle_after"}, {test_busy, test_done, stw_load_en}, 3'b000);
    check_eq({tag, "_fault_hold"}, fault_map, exp_fault);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_ctl"}, {stw_load_en, stw_start, test_busy, test_done, fault_map, fault_any},
             12'h000);
    check_eq({tag, "_ops"}, {stw_mult_op1, stw_mult_op2, stw_add_op, stw_expected}, 64'h0);
  endtask

  initial begin
    int gate_bad;
    int nl;
    bit dn;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Healthy sweep.
    accept_req();
    watch_sweep("healthy", 4, 4'h0, 1'b0);

    // PE2 fails on V1 only.
    fail_pe = 4'b0100; fail_vecs = 4'b0010;
    accept_req();
    watch_sweep("pe2_v1", 4, 4'b0100, 1'b0);
    fail_pe = 4'h0; fail_vecs = 4'h0;

    // Request held off by a busy array; mid-sweep request pulses ignored.
    @(negedge clk);
    test_req = 1'b1; sa_idle = 1'b0;
    gate_bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (test_busy || stw_load_en) gate_bad++;
    end
    check_eq("gate_idle", gate_bad, 0);
    check_eq("gate_fault_hold", fault_map, 4'b0100);
    sa_idle = 1'b1;
    @(posedge clk);
    watch_sweep("gated", 4, 4'h0, 1'b1);

    // Reset in the WAIT state of V2, then a fresh full sweep.
    fail_pe = 4'b0010; fail_vecs = 4'b0001;
    accept_req();
    @(negedge clk);
    test_req = 1'b0;
    repeat (11) @(negedge clk);
    check_eq("pre_rst_fault", fault_map, 4'b0010);
    check_eq("pre_rst_op1", stw_mult_op1, 16'hAAAA);
    check_eq("pre_rst_busy", test_busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_zero("mid_rst");
    rst = 1'b0;
    fail_pe = 4'h0; fail_vecs = 4'h0;
    accept_req();
    watch_sweep("after_rst", 4, 4'h0, 1'b0);

    // Back-to-back: PE3 failing throughout, then healthy.
    fail_pe = 4'b1000; fail_vecs = 4'hF;
    accept_req();
    watch_sweep("pe3", 4, 4'b1000, 1'b0);
    fail_pe = 4'h0; fail_vecs = 4'h0;
    accept_req();
    watch_sweep("b2b", 4, 4'h0, 1'b0);

    // PE0 never completes.
    hang_pe = 4'b0001;
    accept_req();
`ifdef STW_TIMEOUT_EN
    watch_sweep("timeout", Timeout + 3, 4'b0001, 1'b0);
`else
    nl = 0;
    dn = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      test_req = 1'b0;
      if (stw_load_en) nl++;
      if (test_done) dn = 1'b1;
    end
    check_eq("hang_loads", nl, 1);
    check_eq("hang_no_done", dn, 1'b0);
    check_eq("hang_busy", test_busy, 1'b1);
    check_eq("hang_fault", fault_map, 4'h0);
    rst = 1'b1;
    @(negedge clk);
    check_zero("hang_rst");
    rst = 1'b0;
`endif
    hang_pe = 4'h0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
